// File: rtl/neuron_weight_loader_pkg.sv
// rtl/neuron_weight_loader_pkg.sv - shared types, header layout and helpers for the weight loader
package neuron_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SKIP = 2'd2,
        DONE = 2'd3
    } loader_state_e;

    // Neuron index sits in the LSBs of the header word; upper bits are ignored.
    localparam int HDR_IDX_LSB = 0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/neuron_weight_loader_if.sv
// rtl/neuron_weight_loader_if.sv - word stream in, neuron memory write port out
interface neuron_weight_loader_if #(
    parameter int depth       = 3,
    parameter int width       = 8,
    parameter int num_neurons = 4
);
    logic                   valid_i;
    logic [width-1:0]       data_i;
    logic                   ready_o;
    logic [num_neurons-1:0] wen_o;
    logic [depth-1:0]       addr_o;
    logic [width-1:0]       data_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;

    modport master (
        output valid_i, data_i,
        input  ready_o, wen_o, addr_o, data_o, busy_o, done_o, err_o
    );

    modport slave (
        input  valid_i, data_i,
        output ready_o, wen_o, addr_o, data_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/neuron_weight_loader_addr_counter.sv
// rtl/neuron_weight_loader_addr_counter.sv - burst word counter, wraps at 2^depth
module loader_addr_counter #(
    parameter int depth = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [depth-1:0] o_cnt,
    output logic             o_tc
);
    logic [depth-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + depth'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = &r_cnt;
endmodule

// File: rtl/neuron_weight_loader.sv
// rtl/neuron_weight_loader.sv - header-selected burst writer into one of num_neurons weight memories
module neuron_weight_loader
    import neuron_loader_pkg::*;
#(
    parameter int depth       = 3,
    parameter int width       = 8,
    parameter int num_neurons = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    neuron_weight_loader_if.slave bus
);
    localparam int NW = idx_width(num_neurons);

    loader_state_e          r_state;
    loader_state_e          w_next_state;
    logic                   w_ready;
    logic                   w_cnt_clr;
    logic                   w_cnt_en;
    logic                   w_cnt_tc;
    logic [depth-1:0]       w_cnt;
    logic [NW-1:0]          w_idx;
    logic                   w_idx_ok;
    logic                   w_write;
    logic [num_neurons-1:0] w_sel_onehot;
    logic [NW-1:0]          r_sel;
    logic [num_neurons-1:0] r_wen;
    logic [depth-1:0]       r_addr;
    logic [width-1:0]       r_data;
    logic                   r_err;

    assign w_idx    = bus.data_i[HDR_IDX_LSB +: NW];
    assign w_idx_ok = idx_in_range(32'(w_idx), num_neurons);
    assign w_write  = (r_state == LOAD) && bus.valid_i;

    loader_addr_counter #(.depth(depth)) u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_cnt   (w_cnt),
        .o_tc    (w_cnt_tc)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ready depends on state only; LOAD and SKIP count identically so burst timing never leaks the error
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.valid_i) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = w_idx_ok ? LOAD : SKIP;
                end
            end
            LOAD, SKIP: begin
                w_ready = 1'b1;
                if (bus.valid_i) begin
                    w_cnt_en = 1'b1;
                    if (w_cnt_tc) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_sel_onehot = '0;
        for (int n = 0; n < num_neurons; n++) begin
            w_sel_onehot[n] = (r_sel == NW'(n));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sel  <= '0;
            r_wen  <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wen <= '0;
            if (r_state == IDLE && bus.valid_i) begin
                if (w_idx_ok) begin
                    r_sel <= w_idx;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_write) begin
                r_wen  <= w_sel_onehot;
                r_addr <= w_cnt;
                r_data <= bus.data_i;
            end
        end
    end

    assign bus.ready_o = w_ready & ~reset_i;
    assign bus.busy_o  = (r_state == LOAD) || (r_state == SKIP);
    assign bus.done_o  = (r_state == DONE);
    assign bus.wen_o   = r_wen;
    assign bus.addr_o  = r_addr;
    assign bus.data_o  = r_data;
    assign bus.err_o   = r_err;
endmodule

// File: tb/tb_neuron_weight_loader.sv
// tb/tb_neuron_weight_loader.sv - bench driving a 4-neuron and a 3-neuron loader with identical streams
module tb_neuron_weight_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_weight_loader_if #(.depth(3), .width(8), .num_neurons(4)) if4 ();
    neuron_weight_loader_if #(.depth(3), .width(8), .num_neurons(3)) if3 ();

    neuron_weight_loader #(.depth(3), .width(8), .num_neurons(4)) dut4 (
        .clk_i (clk), .reset_i (rst), .bus (if4)
    );
    neuron_weight_loader #(.depth(3), .width(8), .num_neurons(3)) dut3 (
        .clk_i (clk), .reset_i (rst), .bus (if3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_dut [2][4][8];
    logic [7:0] exp_mem [2][4][8];
    int         wen_cnt [2];
    int         done_cnt[2];

    // model: phase -1 = awaiting header, 0..7 = next weight index, 8 = done cycle
    int         m_phase[2];
    int         m_sel  [2];
    bit         m_err  [2];
    logic [3:0] m_wen  [2];
    logic [2:0] m_addr [2];
    logic [7:0] m_data [2];
    bit         m_acc;

    function automatic int nn(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) if (if4.wen_o[n]) mem_dut[0][n][if4.addr_o] = if4.data_o;
        for (int n = 0; n < 3; n++) if (if3.wen_o[n]) mem_dut[1][n][if3.addr_o] = if3.data_o;
        if (if4.wen_o != 0) wen_cnt[0]++;
        if (if3.wen_o != 0) wen_cnt[1]++;
        if (if4.done_o) done_cnt[0]++;
        if (if3.done_o) done_cnt[1]++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = -1;
            m_sel[k]   = -1;
            m_err[k]   = 1'b0;
            m_wen[k]   = '0;
            m_addr[k]  = '0;
            m_data[k]  = '0;
        end
        m_acc = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        int idx;
        for (int k = 0; k < 2; k++) begin
            if (m_wen[k] != 0) exp_mem[k][m_sel[k]][m_addr[k]] = m_data[k];
            m_wen[k] = '0;
            if (m_phase[k] == 8) begin
                m_phase[k] = -1;
                if (k == 0) m_acc = 1'b0;
            end else if (v) begin
                if (k == 0) m_acc = 1'b1;
                if (m_phase[k] == -1) begin
                    idx = int'(d) % 4;
                    m_sel[k] = (idx < nn(k)) ? idx : -1;
                    if (m_sel[k] < 0) m_err[k] = 1'b1;
                    m_phase[k] = 0;
                end else begin
                    if (m_sel[k] >= 0) begin
                        m_wen[k]  = 4'(1 << m_sel[k]);
                        m_addr[k] = 3'(m_phase[k]);
                        m_data[k] = d;
                    end
                    m_phase[k]++;
                end
            end else if (k == 0) begin
                m_acc = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        logic       a_ready, a_busy, a_done, a_err;
        logic [3:0] a_wen;
        logic [2:0] a_addr;
        logic [7:0] a_data;
        for (int k = 0; k < 2; k++) begin
            a_ready = (k == 0) ? if4.ready_o : if3.ready_o;
            a_busy  = (k == 0) ? if4.busy_o  : if3.busy_o;
            a_done  = (k == 0) ? if4.done_o  : if3.done_o;
            a_err   = (k == 0) ? if4.err_o   : if3.err_o;
            a_wen   = (k == 0) ? if4.wen_o   : {1'b0, if3.wen_o};
            a_addr  = (k == 0) ? if4.addr_o  : if3.addr_o;
            a_data  = (k == 0) ? if4.data_o  : if3.data_o;
            chk($sformatf("ready[%0d]", k), 32'(a_ready), 32'(m_phase[k] != 8));
            chk($sformatf("busy[%0d]", k), 32'(a_busy), 32'(m_phase[k] >= 0 && m_phase[k] < 8));
            chk($sformatf("done[%0d]", k), 32'(a_done), 32'(m_phase[k] == 8));
            chk($sformatf("err[%0d]", k), 32'(a_err), 32'(m_err[k]));
            chk($sformatf("wen[%0d]", k), 32'(a_wen), 32'(m_wen[k]));
            if (m_wen[k] != 0) begin
                chk($sformatf("addr[%0d]", k), 32'(a_addr), 32'(m_addr[k]));
                chk($sformatf("wdata[%0d]", k), 32'(a_data), 32'(m_data[k]));
            end
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d);
        if4.valid_i = v;
        if3.valid_i = v;
        if4.data_i  = d;
        if3.data_i  = d;
    endtask

    task automatic cycle(input bit v, input logic [7:0] d);
        @(negedge clk);
        check_outputs();
        drive(v, d);
        @(posedge clk);
        model_step(v, d);
    endtask

    task automatic send_word(input logic [7:0] d);
        int tries = 0;
        do begin
            cycle(1'b1, d);
            tries++;
        end while (!m_acc && tries < 4);
        if (!m_acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept: word %0h not taken within %0d cycles", d, tries);
        end
    endtask

    // gap_mode: 0 continuous, 1 idle cycle before every weight, 2 random idles
    task automatic send_burst(input logic [7:0] hdr, input logic [7:0] base,
                              input bit rnd_data, input int gap_mode);
        logic [7:0] w;
        send_word(hdr);
        for (int i = 0; i < 8; i++) begin
            if (gap_mode == 1) cycle(1'b0, 8'($urandom));
            if (gap_mode == 2) while ($urandom_range(99) < 30) cycle(1'b0, 8'($urandom));
            w = rnd_data ? 8'($urandom) : base + 8'(i);
            send_word(w);
        end
    endtask

    task automatic settle();
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ready4"}, 32'(if4.ready_o), 0);
        chk({tag, " ready3"}, 32'(if3.ready_o), 0);
        chk({tag, " wen4"}, 32'(if4.wen_o), 0);
        chk({tag, " wen3"}, 32'(if3.wen_o), 0);
        chk({tag, " addr4"}, 32'(if4.addr_o), 0);
        chk({tag, " data4"}, 32'(if4.data_o), 0);
        chk({tag, " busy4"}, 32'(if4.busy_o), 0);
        chk({tag, " done4"}, 32'(if4.done_o), 0);
        chk({tag, " err3"}, 32'(if3.err_o), 0);
    endtask

    initial begin
        int w0, d0, w1;
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 4; n++)
                for (int a = 0; a < 8; a++) begin
                    mem_dut[k][n][a] = '0;
                    exp_mem[k][n][a] = '0;
                end
        wen_cnt  = '{0, 0};
        done_cnt = '{0, 0};
        drive(1'b0, 8'h00);
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        w0 = wen_cnt[0]; d0 = done_cnt[0]; w1 = wen_cnt[1];
        send_burst(8'h02, 8'h10, 1'b0, 0);
        settle();
        chk("burst1 wen cycles", 32'(wen_cnt[0] - w0), 8);
        chk("burst1 done pulses", 32'(done_cnt[0] - d0), 1);
        chk("burst1 mem[2][0]", 32'(mem_dut[0][2][0]), 32'h10);
        chk("burst1 mem[2][7]", 32'(mem_dut[0][2][7]), 32'h17);

        send_burst(8'h02, 8'h20, 1'b0, 1);
        settle();
        chk("gapped mem[2][3]", 32'(mem_dut[0][2][3]), 32'h23);

        w1 = wen_cnt[1];
        send_burst(8'h07, 8'h30, 1'b0, 0);
        settle();
        chk("hdr07 err4", 32'(if4.err_o), 0);
        chk("hdr07 err3", 32'(if3.err_o), 1);
        chk("hdr07 dut3 no writes", 32'(wen_cnt[1] - w1), 0);
        chk("hdr07 mem4[3][6]", 32'(mem_dut[0][3][6]), 32'h36);

        send_burst(8'h05, 8'h50, 1'b0, 0);
        settle();
        chk("hdr05 mem3[1][2]", 32'(mem_dut[1][1][2]), 32'h52);

        send_burst(8'h00, 8'h60, 1'b0, 0);
        send_burst(8'h01, 8'h70, 1'b0, 0);
        settle();
        chk("b2b mem4[0][7]", 32'(mem_dut[0][0][7]), 32'h67);
        chk("b2b mem4[1][0]", 32'(mem_dut[0][1][0]), 32'h70);

        send_word(8'h00);
        for (int i = 0; i < 4; i++) send_word(8'h80 + 8'(i));
        @(negedge clk);
        drive(1'b0, 8'h00);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_burst(8'h01, 8'h40, 1'b0, 0);
        settle();
        chk("after reset mem4[1][0]", 32'(mem_dut[0][1][0]), 32'h40);
        chk("after reset mem4[1][7]", 32'(mem_dut[0][1][7]), 32'h47);

        for (int b = 0; b < 24; b++) begin
            send_burst(8'($urandom), 8'h00, 1'b1, 2);
            if ($urandom_range(3) == 0) cycle(1'b0, 8'h00);
        end
        settle();

        for (int k = 0; k < 2; k++)
            for (int n = 0; n < nn(k); n++)
                for (int a = 0; a < 8; a++)
                    chk($sformatf("readback d%0d n%0d a%0d", k, n, a),
                        32'(mem_dut[k][n][a]), 32'(exp_mem[k][n][a]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neuron_weight_loader.md
# neuron_weight_loader

Write-side counterpart of the per-neuron weight ROMs: accepts a valid/ready stream of weight words and writes them into a selected neuron's weight memory through its write-data/write-enable port. Sits between the off-chip configuration interface and the bank of writable neuron memories in one layer. Each load burst is one header word selecting the neuron, then exactly 2^depth weight words written to addresses 0..2^depth-1.

## Interface
- depth, 3, address bits of each neuron memory; burst length is 2^depth words
- width, 8, bits per weight word and per header word
- num_neurons, 4, neurons in the layer; 1..2^width; index width NW = max(1, $clog2(num_neurons))
- clk_i  input  1  clock, all state on rising edge
- reset_i  input  1  asynchronous, active-high reset
- valid_i  input  1  upstream word valid
- data_i  input  width  header or weight word
- ready_o  output  1  loader accepts data_i this cycle
- wen_o  output  num_neurons  one-hot write enable, bit n targets neuron n
- addr_o  output  depth  write address, shared by all neurons
- data_o  output  width  write data, shared by all neurons
- busy_o  output  1  a burst is in progress (header accepted, last word not yet accepted)
- done_o  output  1  one-cycle pulse after a burst completes
- err_o  output  1  sticky: a header selected index >= num_neurons; cleared only by reset

## Operation
- Handshake: word transfers when valid_i && ready_o on a rising edge; data_i must be held while valid_i && !ready_o.
- States: IDLE, LOAD, SKIP, DONE.
- IDLE: ready_o=1. On transfer, idx = data_i[NW-1:0], upper header bits ignored; cnt <= 0. idx < num_neurons -> LOAD with sel <= idx; else -> SKIP, err_o <= 1.
- LOAD: ready_o=1. Each transfer issues one write: wen_o[sel], addr_o=cnt, data_o=data_i (registered, see Timing); cnt increments. Transfer at cnt = 2^depth-1 -> DONE.
- SKIP: ready_o=1. Consumes 2^depth words with no writes, same counting; last word -> DONE.
- DONE: ready_o=0 for exactly one cycle, done_o=1 (also after a SKIP burst); then IDLE.
- cnt is depth+0 bits wide and wraps naturally from 2^depth-1 to 0; no separate terminal count register.
- valid_i low in LOAD/SKIP: state and cnt hold, no write, busy_o stays 1; no timeout.
- Reset mid-burst: all state cleared, returns to IDLE; partial writes remain in the memory, contents of that neuron are undefined; next word after reset is a header.

## Timing
- Reset values: ready_o=0 while reset_i asserted, 1 in first cycle after release (IDLE); wen_o=0, addr_o=0, data_o=0, busy_o=0, done_o=0, err_o=0.
- wen_o, addr_o, data_o are registered: the write for a word accepted at edge k is presented during cycle k..k+1 and captured by the memory at edge k+1. wen_o is high for exactly one cycle per accepted weight word, zero otherwise.
- Back-to-back transfers sustain one write per cycle; burst of 2^depth words with continuous valid takes 1 + 2^depth + 1 cycles header-to-IDLE.
- busy_o asserts the cycle after the header edge, deasserts the cycle after the last-word edge (same cycle done_o rises).
- ready_o is a function of state only (no combinational path from valid_i).

## Structure
- Package neuron_loader_pkg: state enum typedef loader_state_e {IDLE, LOAD, SKIP, DONE}; localparam for ascii-free header field layout (index in LSBs).
- One sub-module natural: loader_addr_counter (depth-bit counter, clear, enable, terminal-count flag).
- Top holds FSM, sel register, output registers.

## Test plan
- depth=3,width=8,num_neurons=4: header 0x02 then 0x10..0x17 continuous -> wen_o=4'b0100 for 8 cycles, addr_o 0..7, data_o 0x10..0x17, then done_o one pulse, busy_o low.
- Same burst with valid_i dropped every other cycle -> same 8 writes in order, no wen_o in gap cycles, ready_o stays 1.
- Header 0x07 (index 3 after masking? no: NW=2 -> idx 3, valid) vs header 0x05 with num_neurons=3 -> idx 1 written; header 0x03 with num_neurons=3 -> SKIP, 8 words consumed, wen_o never set, err_o=1 sticky, done_o pulses.
- Two bursts back-to-back (neuron 0 then 1) -> ready_o low exactly one cycle between, second header accepted in IDLE.
- Assert reset_i after 4th weight word -> all outputs 0 immediately; after release, header 0x01 + 8 words loads neuron 1 from address 0.
- Bind 4 writable memories, load all, read back via addr -> every word matches.
